// File: rtl/axil_pkg.sv
// Shared definitions for the audio controller's AXI4-Lite style write path:
// response codes and the write-slave state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    INIT,
    ACCEPT,
    RESP
  } state_t;

endpackage

// File: rtl/axil_reg_write_slave_if.sv
// Write-only AXI4-Lite style bus: AW, W and B channels with master/slave views.
interface axil_reg_write_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic [1:0]        BRESP;
  logic              BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axil_reg_bank.sv
// NUM_REGS x DATA_W register bank with a single write port, exported flat.
module axil_reg_bank #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 7,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [NUM_REGS*DATA_W-1:0] regs
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // we is only raised for in-range addresses, so no bound check is needed here
  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(waddr) == i) mem[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/axil_reg_write_slave.sv
// Write-only AXI4-Lite style slave: AW and W accepted independently, committed
// together into a register bank, with SLVERR for unmapped addresses.
module axil_reg_write_slave
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 7,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       reset,
  axil_reg_write_slave_if.slave      bus,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [NUM_REGS*DATA_W-1:0] regs
);

  if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_params
    $error("axil_reg_write_slave: NUM_REGS exceeds 2**ADDR_W");
  end

  state_t            state, state_n;
  logic              aw_held, aw_held_n;
  logic              w_held, w_held_n;
  logic [ADDR_W-1:0] aw_addr, aw_addr_n;
  logic [DATA_W-1:0] w_data, w_data_n;
  logic              awready, awready_n;
  logic              wready, wready_n;
  logic              bvalid, bvalid_n;
  logic [1:0]        bresp, bresp_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
  logic              bank_we;

  logic              aw_hs, w_hs, aw_take, w_take, in_range;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  // A handshake completing this cycle counts as held, so a same-edge AW+W commits at once
  assign aw_hs    = bus.AWVALID & awready;
  assign w_hs     = bus.WVALID & wready;
  assign aw_take  = aw_held | aw_hs;
  assign w_take   = w_held | w_hs;
  assign addr_sel = aw_hs ? bus.AWADDR : aw_addr;
  assign data_sel = w_hs ? bus.WDATA : w_data;
  assign in_range = int'(addr_sel) < NUM_REGS;

  always_comb begin
    state_n   = state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_addr_n = aw_addr;
    w_data_n  = w_data;
    awready_n = 1'b0;
    wready_n  = 1'b0;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    bank_we   = 1'b0;
    case (state)
      INIT: begin
        state_n   = ACCEPT;
        awready_n = 1'b1;
        wready_n  = 1'b1;
      end
      ACCEPT: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          aw_addr_n = bus.AWADDR;
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          w_data_n = bus.WDATA;
        end
        if (aw_take && w_take) begin
          state_n   = RESP;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = in_range ? RESP_OKAY : RESP_SLVERR;
          wr_en_n   = in_range;
          bank_we   = in_range;
          wr_addr_n = addr_sel;
          wr_data_n = data_sel;
        end else begin
          awready_n = ~aw_take;
          wready_n  = ~w_take;
        end
      end
      RESP: begin
        if (bus.BREADY) begin
          state_n   = ACCEPT;
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      aw_addr <= aw_addr_n;
      w_data  <= w_data_n;
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;

  axil_reg_bank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RESET_VAL(RESET_VAL)
  ) u_bank (
    .ACLK (ACLK),
    .reset(reset),
    .we   (bank_we),
    .waddr(addr_sel),
    .wdata(data_sel),
    .regs (regs)
  );

endmodule

// File: tb/tb_axil_reg_write_slave.sv
// Directed plus randomized write transactions against an array model of the register map.
module tb_axil_reg_write_slave;

  localparam int                ADDR_W    = 4;
  localparam int                DATA_W    = 7;
  localparam int                NUM_REGS  = 10;
  localparam logic [DATA_W-1:0] RESET_VAL = '0;

  logic                       ACLK = 1'b0;
  logic                       reset = 1'b1;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_REGS*DATA_W-1:0] regs;

  axil_reg_write_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_reg_write_slave #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .ACLK   (ACLK),
    .reset  (reset),
    .bus    (bus.slave),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .regs   (regs)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] model [NUM_REGS];

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full write: AW/W presented after independent delays, B held off for b_dly cycles
  task automatic write_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input bit bready_early, input bit poke_aw);
    bit aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, got_b = 0;
    bit exp_ok = (int'(a) < NUM_REGS);
    logic [1:0] exp_resp = exp_ok ? 2'b00 : 2'b10;
    bus.BREADY = bready_early;
    for (int c = 0; c < 40 && !got_b; c++) begin
      @(negedge ACLK);
      if (aw_hs) begin bus.AWVALID = 1'b0; aw_done = 1; aw_hs = 0; end
      if (w_hs)  begin bus.WVALID  = 1'b0; w_done  = 1; w_hs  = 0; end
      if (bus.BVALID) got_b = 1;
      else begin
        if (aw_done) check("awready_after_aw", bus.AWREADY, 1'b0);
        if (w_done)  check("wready_after_w", bus.WREADY, 1'b0);
        check("wr_en_idle", wr_en, 1'b0);
        if (!aw_done && c >= aw_dly) begin bus.AWVALID = 1'b1; bus.AWADDR = a; end
        if (!w_done && c >= w_dly)   begin bus.WVALID  = 1'b1; bus.WDATA  = d; end
        if (bus.AWVALID && bus.AWREADY) aw_hs = 1;
        if (bus.WVALID && bus.WREADY)   w_hs  = 1;
      end
    end
    check("commit_seen", got_b, 1'b1);
    if (!got_b) return;
    check("both_accepted", {aw_done, w_done}, 2'b11);
    if (exp_ok) model[a] = d;
    check("bresp", bus.BRESP, exp_resp);
    check("wr_en_pulse", wr_en, exp_ok);
    check("wr_addr", wr_addr, a);
    check("wr_data", wr_data, d);
    check("regs_commit", regs, model_flat());
    check("readies_in_resp", {bus.AWREADY, bus.WREADY}, 2'b00);
    bus.BREADY = (b_dly == 0);
    for (int k = 0; k < b_dly; k++) begin
      if (poke_aw) begin bus.AWVALID = 1'b1; bus.AWADDR = a ^ 4'd1; end
      @(negedge ACLK);
      check("bvalid_hold", bus.BVALID, 1'b1);
      check("bresp_hold", bus.BRESP, exp_resp);
      check("readies_hold", {bus.AWREADY, bus.WREADY}, 2'b00);
      check("wr_en_one_cycle", wr_en, 1'b0);
      check("regs_hold", regs, model_flat());
    end
    bus.AWVALID = 1'b0;
    bus.BREADY  = 1'b1;
    @(negedge ACLK);
    check("bvalid_release", bus.BVALID, 1'b0);
    check("bresp_release", bus.BRESP, 2'b00);
    check("readies_back", {bus.AWREADY, bus.WREADY}, 2'b11);
    check("regs_after", regs, model_flat());
    bus.BREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    model_reset();
    repeat (2) @(negedge ACLK);
    reset = 1'b0;
    #1;
    check("rst_readies_first", {bus.AWREADY, bus.WREADY}, 2'b00);
    check("rst_bvalid", bus.BVALID, 1'b0);
    check("rst_bresp", bus.BRESP, 2'b00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 4'd0);
    check("rst_wr_data", wr_data, 7'd0);
    check("rst_regs", regs, model_flat());
    @(negedge ACLK);
    check("rst_readies_second", {bus.AWREADY, bus.WREADY}, 2'b11);

    write_txn(4'd3, 7'h55, 0, 0, 0, 1'b1, 1'b0);
    write_txn(4'd5, 7'h12, 3, 0, 0, 1'b0, 1'b0);
    write_txn(4'd12, 7'h7F, 0, 0, 0, 1'b0, 1'b0);
    write_txn(4'd9, 7'h21, 0, 2, 1, 1'b0, 1'b0);
    write_txn(4'd10, 7'h3C, 1, 1, 0, 1'b0, 1'b0);
    write_txn(4'd7, 7'h2A, 1, 1, 5, 1'b0, 1'b1);
    write_txn(4'd2, 7'h33, 0, 0, 0, 1'b0, 1'b0);

    // AW to address 2 accepted, then reset before any W arrives
    @(negedge ACLK);
    bus.AWADDR  = 4'd2;
    bus.AWVALID = 1'b1;
    check("rst_mid_awready", bus.AWREADY, 1'b1);
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    check("rst_mid_aw_held", bus.AWREADY, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_regs", regs, model_flat());
    check("rst_mid_bvalid", bus.BVALID, 1'b0);
    @(negedge ACLK);
    reset = 1'b0;
    #1;
    check("rst_mid_init_readies", {bus.AWREADY, bus.WREADY}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check("rst_mid_no_bvalid", bus.BVALID, 1'b0);
      check("rst_mid_readies", {bus.AWREADY, bus.WREADY}, 2'b11);
    end
    write_txn(4'd2, 7'h44, 0, 1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      write_txn(ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
